// File: rtl/reduce_seq_if.sv
// Request/response bundle for reduce_seq: operand and mode in, reduction result
// and lowest-set-bit index out, each direction with its own valid/ready pair.
`timescale 1ns/1ps
interface reduce_seq_if #(
    parameter int WIDTH = 32,
    parameter int IDXW  = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] src;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic             res;
    logic             idx_valid;
    logic [IDXW-1:0]  idx;

    modport master (
        output in_valid, src, mode, out_ready,
        input  in_ready, out_valid, res, idx_valid, idx
    );

    modport slave (
        input  in_valid, src, mode, out_ready,
        output in_ready, out_valid, res, idx_valid, idx
    );
endinterface

// File: rtl/reduce_seq.sv
// Multi-cycle bit reducer: folds one SLICE-bit chunk of the latched operand per
// cycle into an OR/AND/XOR/NOR accumulator and tracks the lowest set bit.
`timescale 1ns/1ps
module reduce_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    reduce_seq_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNTW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNTW-1:0]  r_k;
    logic [WIDTH-1:0] r_src;
    logic [1:0]       r_mode;
    logic             r_acc;
    logic             r_res;
    logic             r_idxValid;
    logic [IDXW-1:0]  r_idx;

    logic [SLICE-1:0] w_slice;
    logic [IDXW-1:0]  w_base;
    logic [IDXW-1:0]  w_lowOff;
    logic             w_last;
    logic             w_accept;
    logic             w_accNext;

    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_last   = (r_k == CNTW'(NSLICE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_next = RUN;
            RUN:     if (w_last)        w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == IDLE);
        bus.out_valid = (r_state == DONE);
        bus.res       = r_res;
        bus.idx_valid = r_idxValid;
        bus.idx       = r_idx;
    end

    // Select the current slice of the latched operand and its bit offset.
    always_comb begin
        w_slice = '0;
        w_base  = '0;
        for (int s = 0; s < NSLICE; s++) begin
            if (r_k == CNTW'(s)) begin
                w_slice = r_src[s*SLICE +: SLICE];
                w_base  = IDXW'(s * SLICE);
            end
        end
    end

    // Descending scan so the lowest set bit is the last one written.
    always_comb begin
        w_lowOff = '0;
        for (int j = SLICE - 1; j >= 0; j--) begin
            if (w_slice[j]) w_lowOff = IDXW'(j);
        end
    end

    always_comb begin
        case (r_mode)
            2'b01:   w_accNext = r_acc & (&w_slice);
            2'b10:   w_accNext = r_acc ^ (^w_slice);
            default: w_accNext = r_acc | (|w_slice);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k        <= '0;
            r_src      <= '0;
            r_mode     <= '0;
            r_acc      <= 1'b0;
            r_res      <= 1'b0;
            r_idxValid <= 1'b0;
            r_idx      <= '0;
        end else if (w_accept) begin
            r_k        <= '0;
            r_src      <= bus.src;
            r_mode     <= bus.mode;
            r_acc      <= (bus.mode == 2'b01);
            r_idxValid <= 1'b0;
            r_idx      <= '0;
        end else if (r_state == RUN) begin
            r_acc <= w_accNext;
            if (!w_last) begin
                r_k <= r_k + CNTW'(1);
            end
            if (!r_idxValid && (|w_slice)) begin
                r_idxValid <= 1'b1;
                r_idx      <= w_base + w_lowOff;
            end
            // The result only becomes visible once the final slice is folded in.
            if (w_last) begin
                r_res <= (r_mode == 2'b11) ? ~w_accNext : w_accNext;
            end
        end
    end
endmodule

// File: doc/reduce_seq.md
REDUCE_SEQ -- requirements
Module: reduce_seq

Interface
REQ-001 The block SHALL be parametrised as follows (name, default, meaning):
- WIDTH, 32: operand width in bits; at least 2.
- SLICE, 8: bits reduced per cycle; WIDTH SHALL be an integer multiple of SLICE.
- IDXW, clog2(WIDTH): width of the index output.
- Derived NSLICE = WIDTH/SLICE.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 The ports SHALL be (name, direction, width, meaning):
- clk, in, 1: rising-edge clock.
- rst_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: request present.
- in_ready, out, 1: block can accept a request.
- src, in, WIDTH: operand.
- mode, in, 2: reduction select. 00 OR, 01 AND, 10 XOR, 11 NOR.
- out_valid, out, 1: result present.
- out_ready, in, 1: consumer accepts the result.
- res, out, 1: reduction result.
- idx_valid, out, 1: at least one src bit is set.
- idx, out, IDXW: position of the lowest set bit of src.

Function
REQ-004 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-005 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE).
REQ-006 Acceptance SHALL occur on a rising edge with in_valid=1 in IDLE. At that edge, src and mode are latched, the slice counter k is cleared to 0, and the state moves to RUN.
REQ-007 In RUN, each rising edge SHALL fold slice k (latched src bits [k*SLICE +: SLICE]) into the accumulator and increment k.
REQ-008 On the edge that processes slice NSLICE-1, the state SHALL move to DONE. out_valid is therefore high exactly NSLICE cycles after the acceptance edge (1 cycle when SLICE=WIDTH).
REQ-009 Accumulator seeding and combining by mode:
- OR and NOR: seed 0; each slice ORs its bits in. NOR outputs the inverted OR.
- AND: seed 1; each slice ANDs its bits in.
- XOR: seed 0; each slice XORs its bits in.
REQ-010 Index tracking SHALL be independent of mode and SHALL use the latched src.
- At acceptance: idx_valid and idx are cleared.
- The first slice k with any bit set sets idx = k*SLICE + lowest set bit within that slice, and sets idx_valid=1.
- Later slices SHALL NOT modify idx.
- If no bit is set, idx=0 and idx_valid=0.
REQ-011 res, idx and idx_valid SHALL be registered. They SHALL hold stable throughout DONE, and change only in RUN or at acceptance.
REQ-012 In DONE, a rising edge with out_ready=1 SHALL return the state to IDLE. While out_ready=0, the block SHALL remain in DONE indefinitely with all outputs held.
REQ-013 in_valid SHALL be ignored in RUN and DONE. Neither src nor mode is latched in those states.
REQ-014 Changes to src or mode after acceptance SHALL have no effect on the result in progress.
REQ-015 In DONE, the outputs SHALL retain their values after the return to IDLE, until the next acceptance.
REQ-016 Minimum request spacing SHALL be NSLICE+2 cycles: accept, NSLICE RUN edges, DONE handshake edge, then the next acceptance.
REQ-017 Slice counter width SHALL be clog2(NSLICE), minimum 1 bit. The counter SHALL NOT wrap within a request.

Reset
REQ-018 rst_n=0 SHALL immediately, without a clock edge, force the following, and SHALL hold them while rst_n=0:
- state=IDLE and k=0;
- res=0, idx=0, idx_valid=0, out_valid=0;
- in_ready=1.
REQ-019 Reset asserted in RUN or DONE SHALL abort the request with no result delivered. After release, the first edge with in_valid=1 SHALL be accepted normally.

Verification
All scenarios use WIDTH=32, SLICE=8.
REQ-020 OR, src=0x00000000 -> out_valid high 4 cycles after acceptance; res=0, idx_valid=0, idx=0. NOR with the same src -> res=1.
REQ-021 OR, src=0x00010000 -> res=1, idx_valid=1, idx=16. OR, src=0x80000001 -> idx=0 (lowest set bit wins across slices).
REQ-022 AND, src=0xFFFFFFFF -> res=1, idx=0. AND, src=0xFFFF7FFF -> res=0. XOR, src=0x80000001 -> res=0. XOR, src=0x00000007 -> res=1.
REQ-023 Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid, src and mode -> res, idx and idx_valid unchanged, in_ready=0, no acceptance. With out_ready=1 -> IDLE in one edge, then the next request is accepted.
REQ-024 Assert rst_n=0 after 2 RUN edges -> all outputs reset asynchronously and in_ready=1. After release, OR with src=0x00000100 -> res=1, idx=8.
REQ-025 Run back-to-back requests with out_ready tied high -> consecutive acceptances exactly 6 cycles apart, each result correct.
